// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   ID-stage hazard sequencer for the 5-stage MIPS pipeline. Detects load-use
//   and branch-operand hazards against EX and MEM, and drives the PC / IF/ID
//   write enables, the ID/EX bubble and the IF/ID flush. Also keeps a
//   saturating count of cycles in which the PC was held.
// Ports
//   clk, rst                 pipeline clock (rising edge), async active-high reset
//   id_rs, id_rt             source registers of the instruction in ID
//   id_uses_rt               ID instruction reads rt
//   id_branch, id_br_taken   ID instruction is beq/bne; ID redirects PC this cycle
//   ex_mem_read, ex_reg_write, ex_dst   EX load / register-write / destination
//   mem_mem_read, mem_dst    MEM load / destination
//   flush_all                redirect from a later stage, overrides everything
//   pc_write, ifid_write     PC and IF/ID load enables
//   idex_bubble, ifid_flush  nop into ID/EX; clear IF/ID
//   stall_cnt                saturating count of cycles with pc_write==0
module hazard_stall_controller #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_br_taken,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             flush_all,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state, state_nxt;

  logic ex_hit, mem_hit;
  logic lu, br1, br2;

  // Register 0 is hard-wired zero, so a write to it never creates a hazard.
  assign ex_hit  = (ex_dst != '0) &&
                   ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
  assign mem_hit = (mem_dst != '0) &&
                   ((mem_dst == id_rs) || (id_uses_rt && (mem_dst == id_rt)));

  assign lu  = ex_mem_read && ex_hit;
  assign br1 = id_branch && ex_reg_write && !ex_mem_read && ex_hit;
  assign br2 = id_branch && mem_mem_read && mem_hit;

  always_comb begin
    state_nxt   = state;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (rst) begin
      // Outputs are combinational, so reset must also hold the pipeline.
      state_nxt   = IDLE;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (flush_all) begin
      state_nxt   = IDLE;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (state == HOLD) begin
      state_nxt   = IDLE;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (lu || br1 || br2) begin
      // Load feeding a branch needs the value out of MEM, hence two stalls.
      if (lu && id_branch) state_nxt = HOLD;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      ifid_flush  = id_br_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_dst = '0, mem_dst = '0;
  logic       id_uses_rt = 1'b0, id_branch = 1'b0, id_br_taken = 1'b0;
  logic       ex_mem_read = 1'b0, ex_reg_write = 1'b0, mem_mem_read = 1'b0;
  logic       flush_all = 1'b0;

  logic        pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [15:0] stall_cnt;
  logic        pc_write4, ifid_write4, idex_bubble4, ifid_flush4;
  logic [3:0]  stall_cnt4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  ctl;   // {pc_write, ifid_write, idex_bubble, ifid_flush}
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_br_taken(id_br_taken), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_dst(ex_dst), .mem_mem_read(mem_mem_read),
    .mem_dst(mem_dst), .flush_all(flush_all), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt)
  );

  hazard_stall_controller #(.REG_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .id_br_taken(id_br_taken), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_dst(ex_dst), .mem_mem_read(mem_mem_read),
    .mem_dst(mem_dst), .flush_all(flush_all), .pc_write(pc_write4),
    .ifid_write(ifid_write4), .idex_bubble(idex_bubble4), .ifid_flush(ifid_flush4),
    .stall_cnt(stall_cnt4)
  );

  // Monitor: every cycle the outputs are valid; pop the expectation for
  // this cycle and compare away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got=%b want=%b", e.name,
                 {pc_write, ifid_write, idex_bubble, ifid_flush}, e.ctl);
      end
      checks++;
      if (stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, stall_cnt, e.cnt);
      end
      checks++;
      if ({pc_write4, ifid_write4, idex_bubble4, ifid_flush4} !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl4 got=%b want=%b", e.name,
                 {pc_write4, ifid_write4, idex_bubble4, ifid_flush4}, e.ctl);
      end
      checks++;
      if (stall_cnt4 !== e.cnt4) begin
        errors++;
        $display("FAIL %s stall_cnt4 got=%0d want=%0d", e.name, stall_cnt4, e.cnt4);
      end
    end
  end

  // One cycle: apply inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic cyc(input string name, input logic r, input logic fa,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic br, input logic tk,
                     input logic emr, input logic erw, input logic [4:0] ed,
                     input logic mmr, input logic [4:0] md,
                     input logic [3:0] ctl, input logic [15:0] cnt, input logic [3:0] cnt4);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; flush_all = fa; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_branch = br; id_br_taken = tk; ex_mem_read = emr; ex_reg_write = erw;
    ex_dst = ed; mem_mem_read = mmr; mem_dst = md;
    e.name = name; e.ctl = ctl; e.cnt = cnt; e.cnt4 = cnt4;
    sb.push_back(e);
  endtask

  localparam logic [3:0] RUN   = 4'b1100;
  localparam logic [3:0] RUNFL = 4'b1101;
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] RESET = 4'b0011;
  localparam logic [3:0] KILL  = 4'b1111;

  initial begin
    //        name        rst fa rs rt urt br tk emr erw ed mmr md  ctl    cnt cnt4
    cyc("reset0",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RESET, 0, 0);
    cyc("reset1",     1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RESET, 0, 0);
    cyc("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,   0, 0);
    // load-use on rs
    cyc("lu",         0, 0, 8, 0, 0, 0, 0, 1, 1, 8, 0, 0, STALL, 0, 0);
    cyc("lu_after",   0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,   1, 1);
    // load feeding beq via rt: two stalls even though inputs clear
    cyc("lubr1",      0, 0, 3, 9, 1, 1, 0, 1, 1, 9, 0, 0, STALL, 1, 1);
    cyc("lubr_hold",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STALL, 2, 2);
    cyc("lubr_done",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, RUNFL, 3, 3);
    // register 0 never hazards
    cyc("reg0",       0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, RUN,   3, 3);
    // BR1 with taken branch: stall wins, no flush
    cyc("br1_taken",  0, 0, 5, 0, 0, 1, 1, 0, 1, 5, 0, 0, STALL, 3, 3);
    cyc("br_flush",   0, 0, 5, 0, 0, 1, 1, 0, 0, 0, 0, 0, RUNFL, 4, 4);
    // BR2 on rt, then the same without id_uses_rt
    cyc("br2",        0, 0, 2, 7, 1, 1, 0, 0, 0, 0, 1, 7, STALL, 4, 4);
    cyc("br2_no_rt",  0, 0, 2, 7, 0, 1, 0, 0, 0, 0, 1, 7, RUN,   5, 5);
    // flush_all in HOLD
    cyc("lubr_rs",    0, 0, 4, 0, 0, 1, 0, 1, 1, 4, 0, 0, STALL, 5, 5);
    cyc("flush_hold", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, KILL,  6, 6);
    cyc("post_flush", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,   6, 6);
    // flush_all beats a load-use stall in IDLE
    cyc("flush_lu",   0, 1, 8, 0, 0, 0, 1, 1, 1, 8, 0, 0, KILL,  6, 6);
    cyc("post_flu",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,   6, 6);
    // reset asserted while in HOLD
    cyc("lubr_rs2",   0, 0, 4, 0, 0, 1, 0, 1, 1, 4, 0, 0, STALL, 6, 6);
    cyc("rst_hold",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RESET, 0, 0);
    cyc("post_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,   0, 0);
    // 20 consecutive load-use stalls: 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++)
      cyc("sat_stall", 0, 0, 8, 0, 0, 0, 0, 1, 1, 8, 0, 0, STALL,
          16'(i), (i > 15) ? 4'd15 : 4'(i));
    cyc("sat_end",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,  20, 15);
    cyc("sat_hold",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN,  20, 15);

    for (int n = 0; n < 5 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
